// File: rtl/dcache_pkg.sv
// Shared types and constants for the data-cache tag path.
// The tag entry layout is {valid, dirty, tag}, and addresses split into tag/index/offset.
package dcache_pkg;

  localparam int TAG_W   = 23;
  localparam int IDX_W   = 4;
  localparam int OFF_W   = 5;
  localparam int ENTRY_W = TAG_W + 2;

  typedef struct packed {
    logic             valid;
    logic             dirty;
    logic [TAG_W-1:0] tag;
  } tag_entry_t;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  function automatic logic [TAG_W-1:0] addr_tag(input logic [31:0] addr);
    return addr[31:OFF_W+IDX_W];
  endfunction

  function automatic logic [IDX_W-1:0] addr_idx(input logic [31:0] addr);
    return addr[OFF_W+IDX_W-1:OFF_W];
  endfunction

endpackage

// File: rtl/dcache_tag_ctrl.sv
// Tag SRAM sequencer: clears every entry after reset, then gives the single macro port
// to updates (priority) or lookups, returning hit/dirty/victim tag one cycle after accept.
module dcache_tag_ctrl
  import dcache_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               lookup_req,
  input  logic [31:0]        lookup_addr,
  output logic               lookup_ready,
  input  logic               update_req,
  input  logic [IDX_W-1:0]   update_idx,
  input  logic [TAG_W-1:0]   update_tag,
  input  logic               update_valid,
  input  logic               update_dirty,
  output logic               update_ready,
  output logic               resp_valid,
  output logic               resp_hit,
  output logic               resp_dirty,
  output logic [TAG_W-1:0]   resp_tag,
  output logic               init_done,
  output logic               tag_csb0,
  output logic               tag_web0,
  output logic [IDX_W-1:0]   tag_addr0,
  output logic [ENTRY_W-1:0] tag_din0,
  input  logic [ENTRY_W-1:0] tag_dout0
);

  state_t           state, state_next;
  logic [IDX_W-1:0] sweep_cnt;
  logic             resp_pend;
  logic [TAG_W-1:0] lookup_tag_q;
  logic             lookup_go, update_go;
  tag_entry_t       wr_entry, rd_entry;
  logic             unused_offset;

  assign unused_offset = ^lookup_addr[OFF_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= INIT;
      sweep_cnt    <= '0;
      resp_pend    <= 1'b0;
      lookup_tag_q <= '0;
    end else begin
      state     <= state_next;
      resp_pend <= lookup_go;
      if (state == INIT) begin
        sweep_cnt <= sweep_cnt + 1'b1;
      end
      if (lookup_go) begin
        lookup_tag_q <= addr_tag(lookup_addr);
      end
    end
  end

  // While rst is high the index-0 clear write is already driven, so the macro's
  // input registers hold defined values from the first reset edge onward.
  always_comb begin
    state_next = state;
    update_go  = 1'b0;
    lookup_go  = 1'b0;
    tag_csb0   = 1'b1;
    tag_web0   = 1'b1;
    tag_addr0  = '0;
    wr_entry   = '0;
    if (rst) begin
      tag_csb0 = 1'b0;
      tag_web0 = 1'b0;
    end else if (state == INIT) begin
      tag_csb0  = 1'b0;
      tag_web0  = 1'b0;
      tag_addr0 = sweep_cnt;
      if (sweep_cnt == '1) begin
        state_next = RUN;
      end
    end else if (update_req) begin
      update_go      = 1'b1;
      tag_csb0       = 1'b0;
      tag_web0       = 1'b0;
      tag_addr0      = update_idx;
      wr_entry.valid = update_valid;
      wr_entry.dirty = update_dirty;
      wr_entry.tag   = update_tag;
    end else if (lookup_req) begin
      lookup_go = 1'b1;
      tag_csb0  = 1'b0;
      tag_web0  = 1'b1;
      tag_addr0 = addr_idx(lookup_addr);
    end
  end

  assign tag_din0     = wr_entry;
  assign lookup_ready = lookup_go;
  assign update_ready = update_go;
  assign init_done    = (state == RUN);

  // Read data is combinational from the macro, so the response is formed in the cycle after accept.
  assign rd_entry   = tag_dout0;
  assign resp_valid = resp_pend & ~rst;
  assign resp_hit   = resp_valid & rd_entry.valid & (rd_entry.tag == lookup_tag_q);
  assign resp_dirty = resp_valid & rd_entry.dirty;
  assign resp_tag   = resp_valid ? rd_entry.tag : '0;

endmodule

// File: tb/tb_dcache_tag_ctrl.sv
// Bench for dcache_tag_ctrl: behavioural tag macro, abstract cache-state model with a
// per-cycle comparator, and directed sequences with literal expectations.
module tb_dcache_tag_ctrl;
  import dcache_pkg::*;

  logic               clk = 1'b0;
  logic               rst;
  logic               lookup_req;
  logic [31:0]        lookup_addr;
  logic               lookup_ready;
  logic               update_req;
  logic [3:0]         update_idx;
  logic [22:0]        update_tag;
  logic               update_valid;
  logic               update_dirty;
  logic               update_ready;
  logic               resp_valid;
  logic               resp_hit;
  logic               resp_dirty;
  logic [22:0]        resp_tag;
  logic               init_done;
  logic               tag_csb0;
  logic               tag_web0;
  logic [3:0]         tag_addr0;
  logic [24:0]        tag_din0;
  logic [24:0]        tag_dout0;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  dcache_tag_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .lookup_req   (lookup_req),
    .lookup_addr  (lookup_addr),
    .lookup_ready (lookup_ready),
    .update_req   (update_req),
    .update_idx   (update_idx),
    .update_tag   (update_tag),
    .update_valid (update_valid),
    .update_dirty (update_dirty),
    .update_ready (update_ready),
    .resp_valid   (resp_valid),
    .resp_hit     (resp_hit),
    .resp_dirty   (resp_dirty),
    .resp_tag     (resp_tag),
    .init_done    (init_done),
    .tag_csb0     (tag_csb0),
    .tag_web0     (tag_web0),
    .tag_addr0    (tag_addr0),
    .tag_din0     (tag_din0),
    .tag_dout0    (tag_dout0)
  );

  // Macro model: inputs registered on the edge, write committed on the next edge.
  // Contents start as valid junk with tag 0x0D so a skipped clear shows up as a hit.
  logic [24:0] mem [16];
  logic        csb_q, web_q;
  logic [3:0]  addr_q;
  logic [24:0] din_q;
  bit          fresh = 1'b1;

  always @(posedge clk) begin
    if (fresh) begin
      for (int i = 0; i < 16; i++) mem[i] <= {2'b11, 23'h0D};
      fresh <= 1'b0;
    end else if (!csb_q && !web_q) begin
      mem[addr_q] <= din_q;
    end
    csb_q  <= tag_csb0;
    web_q  <= tag_web0;
    addr_q <= tag_addr0;
    din_q  <= tag_din0;
  end

  assign tag_dout0 = mem[addr_q];

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Abstract model: cache contents, cycles since reset, and the response owed next cycle.
  logic [24:0] model_mem [16];
  int          since_rst = 0;
  bit          started = 1'b0;
  bit          pend = 1'b0;
  logic [24:0] pend_entry;
  logic [22:0] pend_tag;

  always @(posedge clk) begin
    if (rst) begin
      started   = 1'b1;
      since_rst = 0;
      pend      = 1'b0;
      for (int i = 0; i < 16; i++) model_mem[i] = '0;
    end else if (started) begin
      pend = 1'b0;
      if (since_rst >= 16) begin
        if (update_req) begin
          model_mem[update_idx] = {update_valid, update_dirty, update_tag};
        end else if (lookup_req) begin
          pend       = 1'b1;
          pend_entry = model_mem[lookup_addr[8:5]];
          pend_tag   = lookup_addr[31:9];
        end
      end
      if (since_rst < 100000) since_rst++;
    end
  end

  logic exp_run, exp_upd, exp_lk, exp_rv;

  always @(negedge clk) begin
    if (started) begin
      exp_run = !rst && since_rst >= 16;
      exp_upd = exp_run && update_req;
      exp_lk  = exp_run && lookup_req && !update_req;
      exp_rv  = pend && !rst;
      check_output("init_done", 32'(init_done), 32'(since_rst >= 16));
      check_output("update_ready", 32'(update_ready), 32'(exp_upd));
      check_output("lookup_ready", 32'(lookup_ready), 32'(exp_lk));
      check_output("resp_valid", 32'(resp_valid), 32'(exp_rv));
      if (exp_rv) begin
        check_output("resp_hit", 32'(resp_hit), 32'(pend_entry[24] && pend_entry[22:0] == pend_tag));
        check_output("resp_dirty", 32'(resp_dirty), 32'(pend_entry[23]));
        check_output("resp_tag", 32'(resp_tag), 32'(pend_entry[22:0]));
      end
      if (rst || since_rst < 16) begin
        check_output("clr_csb", 32'(tag_csb0), 32'(0));
        check_output("clr_web", 32'(tag_web0), 32'(0));
        check_output("clr_addr", 32'(tag_addr0), rst ? 32'(0) : 32'(since_rst));
        check_output("clr_din", 32'(tag_din0), 32'(0));
      end else if (exp_upd) begin
        check_output("upd_csb", 32'(tag_csb0), 32'(0));
        check_output("upd_web", 32'(tag_web0), 32'(0));
        check_output("upd_addr", 32'(tag_addr0), 32'(update_idx));
        check_output("upd_din", 32'(tag_din0), 32'({update_valid, update_dirty, update_tag}));
      end else if (exp_lk) begin
        check_output("lk_csb", 32'(tag_csb0), 32'(0));
        check_output("lk_web", 32'(tag_web0), 32'(1));
        check_output("lk_addr", 32'(tag_addr0), 32'(lookup_addr[8:5]));
      end else begin
        check_output("idle_csb", 32'(tag_csb0), 32'(1));
      end
    end
  end

  task automatic apply_stimulus(input logic upd, input logic [3:0] idx, input logic [22:0] tag,
                                input logic v, input logic d, input logic lk, input logic [31:0] addr);
    update_req   = upd;
    update_idx   = idx;
    update_tag   = tag;
    update_valid = v;
    update_dirty = d;
    lookup_req   = lk;
    lookup_addr  = addr;
    #1;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_sweep(input string name);
    int n = 0;
    while (!init_done && n < 40) begin
      cycle();
      n++;
    end
    check_output(name, 32'(n), 32'd16);
  endtask

  initial begin
    rst = 1'b1;
    apply_stimulus(0, 4'd0, 23'd0, 0, 0, 1, 32'h0000_1A40);
    cycle();
    check_output("rst_resp_tag", 32'(resp_tag), 32'd0);
    check_output("rst_init_done", 32'(init_done), 32'd0);
    cycle();
    rst = 1'b0;
    #1;
    wait_sweep("sweep_len");

    // First accept right as init_done rises: cleared entry misses.
    check_output("first_accept", 32'(lookup_ready), 32'd1);
    cycle();
    check_output("miss_valid", 32'(resp_valid), 32'd1);
    check_output("miss_hit", 32'(resp_hit), 32'd0);
    apply_stimulus(1, 4'd2, 23'h0D, 1, 0, 0, 32'h0);
    check_output("fill_ready", 32'(update_ready), 32'd1);
    cycle();
    apply_stimulus(0, 4'd0, 23'd0, 0, 0, 1, 32'h0000_1A40);
    cycle();
    check_output("raw_hit", 32'(resp_hit), 32'd1);
    check_output("raw_tag", 32'(resp_tag), 32'h0D);
    check_output("raw_dirty", 32'(resp_dirty), 32'd0);

    // Simultaneous update and lookup on index 5.
    apply_stimulus(1, 4'd5, 23'h15, 1, 1, 1, 32'h0000_2AA0);
    check_output("both_upd_rdy", 32'(update_ready), 32'd1);
    check_output("both_lk_rdy", 32'(lookup_ready), 32'd0);
    cycle();
    apply_stimulus(0, 4'd0, 23'd0, 0, 0, 1, 32'h0000_2AA0);
    check_output("held_lk_rdy", 32'(lookup_ready), 32'd1);
    cycle();
    check_output("held_hit", 32'(resp_hit), 32'd1);
    check_output("held_dirty", 32'(resp_dirty), 32'd1);

    // Dirty victim at index 7 with a different lookup tag.
    apply_stimulus(1, 4'd7, 23'h7FFFFF, 1, 1, 0, 32'h0);
    cycle();
    apply_stimulus(0, 4'd0, 23'd0, 0, 0, 1, 32'h0000_02E0);
    cycle();
    check_output("victim_hit", 32'(resp_hit), 32'd0);
    check_output("victim_dirty", 32'(resp_dirty), 32'd1);
    check_output("victim_tag", 32'(resp_tag), 32'h7FFFFF);

    // Back-to-back lookups with no bubbles.
    apply_stimulus(0, 4'd0, 23'd0, 0, 0, 1, 32'h0000_1A40);
    cycle();
    apply_stimulus(0, 4'd0, 23'd0, 0, 0, 1, 32'h0000_2AA0);
    check_output("b2b_hit0", 32'(resp_hit), 32'd1);
    cycle();
    apply_stimulus(0, 4'd0, 23'd0, 0, 0, 1, 32'h0000_1A40);
    check_output("b2b_tag1", 32'(resp_tag), 32'h15);
    cycle();

    // Reset the cycle after an accept: the response is dropped and the clear restarts.
    rst = 1'b1;
    apply_stimulus(0, 4'd0, 23'd0, 0, 0, 0, 32'h0);
    check_output("drop_valid", 32'(resp_valid), 32'd0);
    cycle();
    check_output("rerst_done", 32'(init_done), 32'd0);
    rst = 1'b0;
    apply_stimulus(0, 4'd0, 23'd0, 0, 0, 1, 32'h0000_1A40);
    wait_sweep("resweep_len");
    cycle();
    check_output("post_valid", 32'(resp_valid), 32'd1);
    check_output("post_hit", 32'(resp_hit), 32'd0);
    apply_stimulus(0, 4'd0, 23'd0, 0, 0, 0, 32'h0);
    cycle();
    cycle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
